// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RV32 core: streams a program into
// instruction memory, then gates core execution with halt/step/resume control.
module core_run_ctrl #(
  parameter int          ADDR_W     = 8,
  parameter int          CYC_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       core_pc,
  input  logic [31:0]       core_instr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              core_run,
  output logic [2:0]        state,
  output logic [1:0]        halt_cause,
  output logic              done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_cnt,
  output logic [CYC_W-1:0]  cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_RUN    = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam logic [1:0]    C_NONE  = 2'd0;
  localparam logic [1:0]    C_ECALL = 2'd1;
  localparam logic [1:0]    C_BP    = 2'd2;
  localparam logic [1:0]    C_EXT   = 2'd3;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          cause_q, cause_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic                mask_q, mask_d;

  logic                xfer;
  logic                hit_ecall;
  logic [1:0]          hit_cause;
  logic [ADDR_W:0]     idx;

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cause_d    = cause_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    mask_d     = mask_q;
    core_run   = 1'b0;
    ld_ready   = (state_q != S_RUN);
    core_reset = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_READY);
    xfer       = ld_valid & ld_ready;
    hit_ecall  = (core_instr == HALT_INSTR);

    // The breakpoint is masked for one cycle after a resume so the core can leave it.
    if (hit_ecall)                                  hit_cause = C_ECALL;
    else if (bp_en && core_pc == bp_addr && !mask_q) hit_cause = C_BP;
    else if (halt_req)                              hit_cause = C_EXT;
    else                                            hit_cause = C_NONE;

    idx = (state_q == S_LOAD) ? cnt_q : '0;

    if (xfer) begin
      if (state_q != S_LOAD) begin
        err_d   = 1'b0;
        done_d  = 1'b0;
        cause_d = C_NONE;
        cyc_d   = '0;
      end
      if (idx != DEPTH) begin
        we_d    = 1'b1;
        addr_d  = idx[ADDR_W-1:0];
        wdata_d = ld_data;
        cnt_d   = idx + 1'b1;
      end else begin
        cnt_d   = idx;
        err_d   = 1'b1;
      end
      state_d = ld_last ? S_READY : S_LOAD;
    end else begin
      case (state_q)
        S_READY: if (start) begin
          state_d = S_RUN;
          cyc_d   = '0;
          mask_d  = 1'b0;
        end
        S_RUN: begin
          mask_d = 1'b0;
          if (hit_cause != C_NONE) begin
            state_d = S_HALTED;
            cause_d = hit_cause;
            done_d  = (hit_cause == C_ECALL);
          end else begin
            core_run = 1'b1;
          end
        end
        S_HALTED: if (cause_q != C_ECALL) begin
          if (start) begin
            state_d = S_RUN;
            mask_d  = 1'b1;
          end else if (step) begin
            // Stepping onto ECALL ends the program instead of committing it.
            if (hit_ecall) begin
              cause_d = C_ECALL;
              done_d  = 1'b1;
            end else begin
              core_run = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (core_run && cyc_q != '1) cyc_d = cyc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cause_q <= C_NONE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cause_q <= cause_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      mask_q  <= mask_d;
    end
  end

  assign state      = state_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign halt_cause = cause_q;
  assign done       = done_q;
  assign load_err   = err_q;
  assign load_cnt   = cnt_q;
  assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: a toy core plus imem around the DUT, directed
// scenarios then random traffic, every cycle compared to a reference model.
module tb_core_run_ctrl;
  localparam int          AW      = 3;
  localparam int          CW      = 4;
  localparam int          DEPTH   = 1 << AW;
  localparam int          CYC_MAX = (1 << CW) - 1;
  localparam logic [31:0] HALT    = 32'h00000073;

  logic          clk = 1'b0;
  logic          reset, ld_valid, ld_last, start, step, halt_req, bp_en;
  logic [31:0]   ld_data, bp_addr, core_pc, core_instr;
  logic          ld_ready, imem_we, core_reset, core_run, done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [2:0]    state;
  logic [1:0]    halt_cause;
  logic [AW:0]   load_cnt;
  logic [CW-1:0] cycle_cnt;

  always #5 clk = ~clk;

  core_run_ctrl #(.ADDR_W(AW), .CYC_W(CW), .HALT_INSTR(HALT)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .step(step),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(core_pc),
    .core_instr(core_instr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .core_run(core_run),
    .state(state), .halt_cause(halt_cause), .done(done), .load_err(load_err),
    .load_cnt(load_cnt), .cycle_cnt(cycle_cnt)
  );

  int n_chk = 0, n_fail = 0, n_wr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Environment: toy core memory and PC
  logic [31:0] mem [DEPTH];
  logic [31:0] pc = 32'h0;
  logic [31:0] pbuf [16];

  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (a[31:AW+2] == '0) return mem[a[AW+1:2]];
    return 32'h00000013;
  endfunction

  // Reference model, states numbered as the externally visible encoding
  int          m_st = 0, m_cnt = 0, m_cause = 0, m_cyc = 0, m_addr = 0;
  bit          m_err = 0, m_done = 0, m_mask = 0, m_we = 0, m_rst = 1;
  logic [31:0] m_wdata = 32'h0;

  task automatic tick();
    int          hit;
    bit          xfer, e_run, we_s;
    logic [AW-1:0] a_s;
    logic [31:0] d_s, pc_n;
    core_pc    = pc;
    core_instr = fetch(pc);
    #1;
    hit = 0;
    if (m_st == 3) begin
      if (core_instr == HALT)                                  hit = 1;
      else if (bp_en && core_pc == bp_addr && !m_mask)         hit = 2;
      else if (halt_req)                                       hit = 3;
    end
    xfer  = ld_valid && (m_st != 3);
    e_run = (m_st == 3 && hit == 0) ||
            (m_st == 4 && m_cause != 1 && !ld_valid && !start && step && core_instr != HALT);

    chk("state",      32'(state),      32'(m_st));
    chk("ld_ready",   32'(ld_ready),   32'(m_st != 3));
    chk("core_reset", 32'(core_reset), 32'(m_st <= 2));
    chk("core_run",   32'(core_run),   32'(e_run));
    chk("imem_we",    32'(imem_we),    32'(m_we));
    if (m_we || m_rst) begin
      chk("imem_addr",  32'(imem_addr), m_rst ? 32'h0 : 32'(m_addr));
      chk("imem_wdata", imem_wdata,     m_rst ? 32'h0 : m_wdata);
    end
    chk("halt_cause", 32'(halt_cause), 32'(m_cause));
    chk("done",       32'(done),       32'(m_done));
    chk("load_err",   32'(load_err),   32'(m_err));
    chk("load_cnt",   32'(load_cnt),   32'(m_cnt));
    chk("cycle_cnt",  32'(cycle_cnt),  32'(m_cyc));

    we_s = imem_we; a_s = imem_addr; d_s = imem_wdata;
    pc_n = core_reset ? 32'h0 : (core_run ? pc + 32'd4 : pc);

    @(posedge clk);
    if (we_s) begin mem[a_s] = d_s; n_wr++; end
    pc = pc_n;

    m_we = 0; m_rst = 0;
    if (!reset) begin
      m_st = 0; m_cnt = 0; m_err = 0; m_done = 0; m_cause = 0; m_cyc = 0; m_mask = 0; m_rst = 1;
    end else if (xfer) begin
      if (m_st != 1) begin m_cnt = 0; m_err = 0; m_done = 0; m_cause = 0; m_cyc = 0; end
      if (m_cnt < DEPTH) begin
        m_we = 1; m_addr = m_cnt; m_wdata = ld_data; m_cnt++;
      end else m_err = 1;
      m_st = ld_last ? 2 : 1;
    end else begin
      if (e_run && m_cyc < CYC_MAX) m_cyc++;
      if (m_st == 2 && start) begin
        m_st = 3; m_cyc = 0;
      end else if (m_st == 3) begin
        m_mask = 0;
        if (hit != 0) begin m_st = 4; m_cause = hit; m_done = (hit == 1); end
      end else if (m_st == 4 && m_cause != 1) begin
        if (start) begin m_st = 3; m_mask = 1; end
        else if (step && core_instr == HALT) begin m_cause = 1; m_done = 1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic load_words(input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin ld_valid = 1'b0; repeat (2) tick(); end
      ld_valid = 1'b1; ld_data = pbuf[i]; ld_last = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input int max);
    int k = 0;
    while (state != 3'd4 && k < max) begin tick(); k++; end
    chk(tag, 32'(k < max), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h00000013;
    reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; start = 1'b0;
    step = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = '0;
    core_pc = '0; core_instr = 32'h13;
    @(posedge clk); @(negedge clk);
    tick();
    reset = 1'b1;
    tick();

    // Program load and run to ECALL
    pbuf[0] = 32'h00500093; pbuf[1] = 32'h00108113; pbuf[2] = 32'h00000013; pbuf[3] = HALT;
    n_wr = 0;
    load_words(4, -1);
    chk("s1_writes", 32'(n_wr), 32'd4);
    chk("s1_state", 32'(state), 32'd2);
    chk("s1_cnt", 32'(load_cnt), 32'd4);
    chk("s1_mem3", mem[3], HALT);
    pulse_start();
    run_until_halt("s2_halt_timeout", 20);
    chk("s2_pc", pc, 32'hC);
    chk("s2_cause", 32'(halt_cause), 32'd1);
    chk("s2_cyc", 32'(cycle_cnt), 32'd3);
    pulse_start();
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("s2_pc_after", pc, 32'hC);
    chk("s2_cyc_after", 32'(cycle_cnt), 32'd3);

    // Breakpoint, step, resume
    load_words(4, -1);
    bp_en = 1'b1; bp_addr = 32'h8;
    pulse_start();
    run_until_halt("s3_bp_timeout", 20);
    chk("s3_pc", pc, 32'h8);
    chk("s3_cause", 32'(halt_cause), 32'd2);
    chk("s3_cyc", 32'(cycle_cnt), 32'd2);
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("s3_step_cyc", 32'(cycle_cnt), 32'd3);
    chk("s3_step_pc", pc, 32'hC);
    pulse_start();
    run_until_halt("s3_end_timeout", 20);
    chk("s3_done", 32'(done), 32'd1);
    bp_en = 1'b0;

    // Overflow with a gap in the stream
    for (int i = 0; i < 10; i++) pbuf[i] = 32'h10000013 + (32'(i) << 8);
    n_wr = 0;
    load_words(10, 3);
    chk("s4_writes", 32'(n_wr), 32'd8);
    chk("s4_err", 32'(load_err), 32'd1);
    chk("s4_cnt", 32'(load_cnt), 32'd8);
    chk("s4_state", 32'(state), 32'd2);

    // External halt, long resume to saturate, reset mid-run
    for (int i = 0; i < 4; i++) pbuf[i] = 32'h00000013;
    load_words(4, -1);
    pulse_start();
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("s5_cause", 32'(halt_cause), 32'd3);
    chk("s5_state", 32'(state), 32'd4);
    pulse_start();
    repeat (20) tick();
    chk("s5_sat", 32'(cycle_cnt), 32'(CYC_MAX));
    reset = 1'b0; tick(); reset = 1'b1;
    chk("s5_rst_state", 32'(state), 32'd0);
    chk("s5_rst_cyc", 32'(cycle_cnt), 32'd0);
    tick();

    // Load beats start in READY
    pbuf[0] = 32'h00500093; pbuf[1] = 32'h00108113; pbuf[2] = 32'h00000013; pbuf[3] = HALT;
    load_words(4, -1);
    ld_valid = 1'b1; start = 1'b1; ld_data = 32'h00000013; ld_last = 1'b0;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    tick();
    chk("s6_state", 32'(state), 32'd1);
    chk("s6_cnt", 32'(load_cnt), 32'd1);
    pbuf[0] = HALT;
    load_words(1, -1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 299) != 0);
      ld_valid = (m_st == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      ld_last  = ($urandom_range(0, 6) == 0);
      ld_data  = ($urandom_range(0, 3) == 0) ? HALT : (($urandom & 32'hFFFFFF00) | 32'h13);
      start    = ($urandom_range(0, 9) == 0);
      step     = ($urandom_range(0, 5) == 0);
      halt_req = ($urandom_range(0, 14) == 0);
      bp_en    = ($urandom_range(0, 1) == 0);
      bp_addr  = 32'($urandom_range(0, 9)) << 2;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
